wshb_arbiter: RTL

//  Two-master Wishbone arbiter sharing one SDRAM controller slave port.
//  m0 = VGA frame reader (cyc/stb held high permanently); m1 = frame writer (pattern/CPU).

---
 rtl/wshb_arbiter_pkg.sv | 17 +
 rtl/wshb_arbiter_if.sv | 31 +++
 rtl/wshb_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wshb_arbiter_pkg.sv
// Shared types and field widths for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int CTI_W = 3;
    localparam int BTE_W = 2;

    function automatic int sel_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wshb_arbiter_if.sv
// Wishbone B4 classic/burst bus bundle; master drives the request, slave returns ack/data.
interface wshb_if
    import wshb_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    localparam int SEL_W = sel_width(DATA_W);

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_ms;
    logic [SEL_W-1:0]  sel;
    logic [CTI_W-1:0]  cti;
    logic [BTE_W-1:0]  bte;
    logic              ack;
    logic [DATA_W-1:0] dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, dat_sm
    );

endinterface

// File: rtl/wshb_arbiter.sv
// Preemptive round-robin arbiter: two Wishbone masters onto one SDRAM slave port.
// Optional ARB_STAT_EN adds per-master delivered-ack counters for bandwidth debug.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int MAX_ACKS = 64
) (
    input  logic  CLK,
    input  logic  rst,
    wshb_if.slave  m0,
    wshb_if.slave  m1,
    wshb_if.master s
`ifdef ARB_STAT_EN
    ,
    output logic [31:0] m0_ack_cnt,
    output logic [31:0] m1_ack_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_ACKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ACKS - 1);

    arb_state_t       r_state;
    arb_state_t       w_state;
    logic             r_last;
    logic             w_last;
    logic [CNT_W-1:0] r_ack_cnt;
    logic [CNT_W-1:0] w_ack_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_turn_done;

    // Arbitration state registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_ack_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_last    <= w_last;
            r_ack_cnt <= w_ack_cnt;
        end
    end

    // Counter saturates so a long solo tenure hands over on the first ack after a new request
    assign w_cnt_inc   = (r_ack_cnt == CNT_LAST) ? r_ack_cnt : r_ack_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_turn_done = s.ack && (r_ack_cnt == CNT_LAST);

    // Next-state: grant from IDLE, preempt on the last ack of a turn, release on cyc drop
    always_comb begin
        w_state   = r_state;
        w_last    = r_last;
        w_ack_cnt = r_ack_cnt;
        case (r_state)
            IDLE: begin
                w_ack_cnt = '0;
                if (m0.cyc && (!m1.cyc || r_last)) begin
                    w_state = GNT0;
                end else if (m1.cyc) begin
                    w_state = GNT1;
                end else begin
                    w_state = IDLE;
                end
            end
            GNT0: begin
                if (w_turn_done && m1.cyc) begin
                    w_state   = GNT1;
                    w_last    = 1'b0;
                    w_ack_cnt = '0;
                end else if (!m0.cyc) begin
                    w_state   = IDLE;
                    w_last    = 1'b0;
                    w_ack_cnt = '0;
                end else if (s.ack) begin
                    w_ack_cnt = w_cnt_inc;
                end else begin
                    w_ack_cnt = r_ack_cnt;
                end
            end
            GNT1: begin
                if (w_turn_done && m0.cyc) begin
                    w_state   = GNT0;
                    w_last    = 1'b1;
                    w_ack_cnt = '0;
                end else if (!m1.cyc) begin
                    w_state   = IDLE;
                    w_last    = 1'b1;
                    w_ack_cnt = '0;
                end else if (s.ack) begin
                    w_ack_cnt = w_cnt_inc;
                end else begin
                    w_ack_cnt = r_ack_cnt;
                end
            end
            default: begin
                w_state   = IDLE;
                w_last    = 1'b1;
                w_ack_cnt = '0;
            end
        endcase
    end

    // Slave-side mux: the owner's request passes through, IDLE drives a quiet bus
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.dat_ms = '0;
        s.sel    = '0;
        s.cti    = '0;
        s.bte    = '0;
        case (r_state)
            GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.dat_ms = m0.dat_ms;
                s.sel    = m0.sel;
                s.cti    = m0.cti;
                s.bte    = m0.bte;
            end
            GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.dat_ms = m1.dat_ms;
                s.sel    = m1.sel;
                s.cti    = m1.cti;
                s.bte    = m1.bte;
            end
            IDLE: begin
                s.cyc = 1'b0;
            end
            default: begin
                s.cyc = 1'b0;
            end
        endcase
    end

    assign m0.ack    = s.ack && (r_state == GNT0);
    assign m1.ack    = s.ack && (r_state == GNT1);
    assign m0.dat_sm = s.dat_sm;
    assign m1.dat_sm = s.dat_sm;

`ifdef ARB_STAT_EN
    logic [31:0] r_m0_ack_cnt;
    logic [31:0] r_m1_ack_cnt;

    // Free-running delivered-ack counters, wrapping at 2^32
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_m0_ack_cnt <= 32'd0;
            r_m1_ack_cnt <= 32'd0;
        end else begin
            if (m0.ack) begin
                r_m0_ack_cnt <= r_m0_ack_cnt + 32'd1;
            end
            if (m1.ack) begin
                r_m1_ack_cnt <= r_m1_ack_cnt + 32'd1;
            end
        end
    end

    assign m0_ack_cnt = r_m0_ack_cnt;
    assign m1_ack_cnt = r_m1_ack_cnt;
`endif

endmodule
